imem_loader: RTL and testbench

//   Writer side of the instruction-memory interface: receives a byte stream and writes

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that assembles 32-bit words into instruction memory and holds the
// fetch enables low until a full image is written. Optional checksum word: `define CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              enable_pc,
  output logic              enable_ifid
);

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [ADDR_W:0]   count_reg;
  logic [31:0]       shift_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              we_reg;
  logic              done_reg;
  logic              run_reg;
  logic              err_reg;
`ifdef CHECKSUM_EN
  logic [31:0]       xor_reg;
`endif

  logic        ready_c;
  logic        busy_c;
  logic        start_go;
  logic        byte_take;
  logic        word_full;
  logic        last_word;
  logic [31:0] assembled;

  assign start_go  = (state_reg == IDLE) && start;
  assign byte_take = byte_valid && ready_c;
  assign word_full = byte_take && (byte_cnt_reg == 2'd3);
  assign last_word = ((word_cnt_reg + ONE) == count_reg);
  assign assembled = BIG_ENDIAN ? {shift_reg[23:0], byte_in} : {byte_in, shift_reg[31:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (load_words == '0) ? DONE : LOAD;
      end
      LOAD: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (word_full && last_word) begin
`ifdef CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (word_full) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      count_reg    <= '0;
      shift_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      done_reg     <= 1'b0;
      run_reg      <= 1'b0;
      err_reg      <= 1'b0;
`ifdef CHECKSUM_EN
      xor_reg      <= '0;
`endif
    end else begin
      done_reg <= (state_reg == DONE);
      we_reg   <= (state_reg == LOAD) && word_full;

      if (byte_take) begin
        shift_reg    <= assembled;
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
      end

      if ((state_reg == LOAD) && word_full) begin
        wdata_reg    <= assembled;
        word_cnt_reg <= word_cnt_reg + ONE;
`ifdef CHECKSUM_EN
        xor_reg      <= xor_reg ^ assembled;
`endif
      end

      // Address advances once the write strobe has been presented; a saturated
      // load naturally wraps to 0 after the last word.
      if (we_reg) addr_reg <= addr_reg + 1'b1;

`ifdef CHECKSUM_EN
      if ((state_reg == CHECK) && word_full) err_reg <= (assembled != xor_reg);
`endif

      if ((state_reg == DONE) && !err_reg) run_reg <= 1'b1;

      if (start_go) begin
        run_reg      <= 1'b0;
        err_reg      <= 1'b0;
        count_reg    <= (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
        addr_reg     <= '0;
        byte_cnt_reg <= '0;
        word_cnt_reg <= '0;
`ifdef CHECKSUM_EN
        xor_reg      <= '0;
`endif
      end
    end
  end

  assign byte_ready  = ready_c;
  assign busy        = busy_c;
  assign mem_we      = we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign done        = done_reg;
  assign enable_pc   = run_reg;
  assign enable_ifid = run_reg;
`ifdef CHECKSUM_EN
  assign err         = err_reg;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset values, streamed loads with and without gaps,
// zero-length and saturated loads, async abort, and the checksum word when CHECKSUM_EN is set.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   load_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              enable_pc;
  logic              enable_ifid;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .load_words(load_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err),
    .enable_pc(enable_pc), .enable_ifid(enable_ifid)
  );

  always #5 clk = ~clk;

  // Write monitor: one entry per presented write strobe.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    start      = 1'b1;
    load_words = n;
    @(negedge clk);
    start      = 1'b0;
    load_words = '1;
  endtask

  // Called at the negedge right after the last data byte was consumed.
  task automatic post_load(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [31:0] x, input logic exp_en, input logic exp_err);
    check("we_last", 64'(mem_we), 64'd1);
    check("addr_last", 64'(mem_addr), 64'(a));
    check("wdata_last", 64'(mem_wdata), 64'(d));
`ifdef CHECKSUM_EN
    check("ready_chk", 64'(byte_ready), 64'd1);
    for (int k = 0; k < 4; k++) send_byte(x[31-8*k -: 8]);
    check("we_chk", 64'(mem_we), 64'd0);
    check("err_chk", 64'(err), 64'(exp_err));
`else
    check("err_tied", 64'(err), 64'(exp_err & (x != x)));
`endif
    check("ready_end", 64'(byte_ready), 64'd0);
    check("busy_end", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("we_after", 64'(mem_we), 64'd0);
    check("en_pc", 64'(enable_pc), 64'(exp_en));
    check("en_ifid", 64'(enable_ifid), 64'(exp_en));
    @(negedge clk);
    check("done_clear", 64'(done), 64'd0);
    check("en_hold", 64'(enable_pc), 64'(exp_en));
  endtask

  logic [7:0]  prog[8];
  logic [31:0] w;
  logic [31:0] xacc;

  initial begin
    prog[0] = 8'hE3; prog[1] = 8'hA0; prog[2] = 8'h00; prog[3] = 8'h01;
    prog[4] = 8'hE3; prog[5] = 8'hA0; prog[6] = 8'h10; prog[7] = 8'h02;
    reset = 1'b0; start = 1'b0; load_words = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_en_pc", 64'(enable_pc), 64'd0);
    check("rst_en_ifid", 64'(enable_ifid), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Stream data offered while idle must not be consumed.
    byte_valid = 1'b1; byte_in = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready", 64'(byte_ready), 64'd0);
    end
    byte_valid = 1'b0;

    // Two words back to back.
    wa_q.delete(); wd_q.delete();
    do_start(9'd2);
    check("load_busy", 64'(busy), 64'd1);
    check("load_ready", 64'(byte_ready), 64'd1);
    for (int k = 0; k < 8; k++) send_byte(prog[k]);
    post_load(8'd1, 32'hE3A01002, 32'h00001003, 1'b1, 1'b0);
    check("b2b_nwr", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      check("b2b_a0", 64'(wa_q[0]), 64'd0);
      check("b2b_d0", 64'(wd_q[0]), 64'hE3A00001);
      check("b2b_a1", 64'(wa_q[1]), 64'd1);
      check("b2b_d1", 64'(wd_q[1]), 64'hE3A01002);
    end

    // Same image with 3-cycle gaps and a stray start while busy.
    wa_q.delete(); wd_q.delete();
    do_start(9'd2);
    check("start_drops_en", 64'(enable_pc), 64'd0);
    for (int k = 0; k < 8; k++) begin
      send_byte(prog[k]);
      if (k < 7) begin
        for (int g = 0; g < 3; g++) begin
          start      = (k == 0 && g == 0);
          load_words = '0;
          @(negedge clk);
          start = 1'b0;
          check("gap_ready", 64'(byte_ready), 64'd1);
        end
      end
    end
    post_load(8'd1, 32'hE3A01002, 32'h00001003, 1'b1, 1'b0);
    check("gap_nwr", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      check("gap_a0", 64'(wa_q[0]), 64'd0);
      check("gap_d0", 64'(wd_q[0]), 64'hE3A00001);
      check("gap_a1", 64'(wa_q[1]), 64'd1);
      check("gap_d1", 64'(wd_q[1]), 64'hE3A01002);
    end

    // Zero-length load: done two cycles after start, no writes.
    wa_q.delete(); wd_q.delete();
    do_start(9'd0);
    check("z_busy", 64'(busy), 64'd0);
    check("z_en_low", 64'(enable_pc), 64'd0);
    @(negedge clk);
    check("z_done", 64'(done), 64'd1);
    check("z_en", 64'(enable_pc), 64'd1);
    @(negedge clk);
    check("z_done_clear", 64'(done), 64'd0);
    check("z_nwr", 64'(wa_q.size()), 64'd0);

    // Async reset while idle with enables high.
    #2 reset = 1'b0;
    #1;
    check("arst_en_pc", 64'(enable_pc), 64'd0);
    check("arst_en_ifid", 64'(enable_ifid), 64'd0);
    check("arst_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Async abort mid-load.
    do_start(9'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_en", 64'(enable_pc), 64'd0);
    check("abort_idle_ready", 64'(byte_ready), 64'd0);

    // Oversized count saturates at 256 words.
    wa_q.delete(); wd_q.delete();
    xacc = '0;
    do_start(9'd300);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'hA5, 8'h3C};
      xacc = xacc ^ w;
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    end
    post_load(8'd255, {8'hFF, 8'h00, 8'hA5, 8'h3C}, xacc, 1'b1, 1'b0);
    check("sat_addr_wrap", 64'(mem_addr), 64'd0);
    check("sat_nwr", 64'(wa_q.size()), 64'd256);
    if (wa_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check("sat_addr", 64'(wa_q[i]), 64'(i));
        check("sat_data", 64'(wd_q[i]), 64'({i[7:0], ~i[7:0], 8'hA5, 8'h3C}));
      end
    end

`ifdef CHECKSUM_EN
    // Wrong checksum: err set, enables stay low.
    wa_q.delete(); wd_q.delete();
    do_start(9'd2);
    for (int k = 0; k < 8; k++) send_byte(prog[k]);
    post_load(8'd1, 32'hE3A01002, 32'h00000000, 1'b0, 1'b1);
    check("bad_err_sticky", 64'(err), 64'd1);
    check("bad_nwr", 64'(wa_q.size()), 64'd2);
    do_start(9'd0);
    check("err_cleared", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
